// File: rtl/tetris_pkg.sv
// Shared types and helpers for the falling-piece logic.
// Contents:
//   W           - number of board cells (one bitmap bit per cell)
//   move_op_t   - kind of move being evaluated
//   mv_state_t  - piece sequencer states
//   shift_*     - candidate bitmap builders (bit = col + width*row)
package tetris_pkg;

   localparam int W = 150;

   typedef enum logic [1:0] {SPAWN, DOWN, LEFT, RIGHT} move_op_t;

   typedef enum logic [2:0] {EMPTY, IDLE, CHECK, RESOLVE, LOCK, OVER} mv_state_t;

   // One row down means a higher bit index; rows pushed past the bottom fall off.
   function automatic logic [W-1:0] shift_down(input logic [W-1:0] loc, input int play_width);
      return loc << play_width;
   endfunction

   // Column wrap is deliberately not masked here; the validator rejects it.
   function automatic logic [W-1:0] shift_left(input logic [W-1:0] loc);
      return loc >> 1;
   endfunction

   function automatic logic [W-1:0] shift_right(input logic [W-1:0] loc);
      return loc << 1;
   endfunction

endpackage

// File: rtl/piece_move_ctrl_if.sv
// Request/response bundle between the piece sequencer and its surroundings.
// master: request sources and the move validator (drive requests, not_valid).
// slave : piece_move_ctrl (drives candidate, committed location and status).
interface piece_move_ctrl_if;
   import tetris_pkg::*;

   logic         spawn_req;
   logic [W-1:0] spawn_location;
   logic         gravity_tick;
   logic         drop_req;
   logic         left_req;
   logic         right_req;
   logic         req_ready;
   logic [W-1:0] cand_location;
   logic         not_valid;
   logic [W-1:0] cur_location;
   logic         piece_active;
   logic         move_done;
   logic         move_ok;
   logic         piece_lock;
   logic         game_over;

   modport master (
      output spawn_req, spawn_location, gravity_tick, drop_req, left_req, right_req, not_valid,
      input  req_ready, cand_location, cur_location, piece_active, move_done, move_ok,
             piece_lock, game_over
   );

   modport slave (
      input  spawn_req, spawn_location, gravity_tick, drop_req, left_req, right_req, not_valid,
      output req_ready, cand_location, cur_location, piece_active, move_done, move_ok,
             piece_lock, game_over
   );

endinterface

// File: rtl/piece_move_ctrl.sv
// Sequencer for the active falling piece.
// Ports:
//   clk, reset - rising-edge clock, synchronous active-high reset
//   bus        - slave side of piece_move_ctrl_if: spawn/gravity/drop/left/right
//                requests in, candidate bitmap out to the validator, not_valid
//                back, committed location and move/lock/game-over status out.
// A move takes three cycles: accept (IDLE), evaluate (CHECK), report (RESOLVE).
// All outputs come straight from flops.
module piece_move_ctrl
   import tetris_pkg::*;
#(
   parameter int PLAY_WIDTH  = 10,
   parameter int PLAY_HEIGHT = 15,
   parameter int PIX_PER_BLK = 32
) (
   input logic              clk,
   input logic              reset,
   piece_move_ctrl_if.slave bus
);

   // The bitmap width is fixed by the package, so the board geometry must agree.
   generate
      if (PLAY_WIDTH * PLAY_HEIGHT != W || PIX_PER_BLK < 1) begin : g_cfg_check
         $error("piece_move_ctrl: board geometry does not match tetris_pkg::W");
      end
   endgenerate

   mv_state_t    state_q, state_d;
   move_op_t     op_q, op_d;
   logic [W-1:0] cand_q, cand_d;
   logic [W-1:0] cur_q, cur_d;
   logic         active_q, active_d;
   logic         ready_q, ready_d;
   logic         done_q, done_d;
   logic         ok_q, ok_d;
   logic         lock_q, lock_d;
   logic         over_q, over_d;
   logic         grav_q, grav_d;
   logic         grav_req;

   // A tick arriving while IDLE is serviced at once, so it counts as pending too.
   assign grav_req = grav_q | bus.gravity_tick;

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= EMPTY;
         op_q     <= SPAWN;
         cand_q   <= '0;
         cur_q    <= '0;
         active_q <= 1'b0;
         ready_q  <= 1'b0;
         done_q   <= 1'b0;
         ok_q     <= 1'b0;
         lock_q   <= 1'b0;
         over_q   <= 1'b0;
         grav_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cand_q   <= cand_d;
         cur_q    <= cur_d;
         active_q <= active_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         ok_q     <= ok_d;
         lock_q   <= lock_d;
         over_q   <= over_d;
         grav_q   <= grav_d;
      end
   end

   // Next-state logic. The validator verdict is folded into the registered
   // move_done/move_ok/cur_location at the end of CHECK so RESOLVE can show it;
   // RESOLVE then decides whether a failed downward move must lock the piece.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cand_d   = cand_q;
      cur_d    = cur_q;
      active_d = active_q;
      done_d   = 1'b0;
      ok_d     = 1'b0;
      lock_d   = 1'b0;
      over_d   = over_q;
      grav_d   = grav_q | (bus.gravity_tick & (state_q != OVER));

      case (state_q)
         EMPTY: begin
            if (bus.spawn_req) begin
               cand_d  = bus.spawn_location;
               op_d    = SPAWN;
               grav_d  = 1'b0;
               state_d = CHECK;
            end
         end
         IDLE: begin
            if (grav_req) begin
               cand_d  = shift_down(cur_q, PLAY_WIDTH);
               op_d    = DOWN;
               grav_d  = grav_q & bus.gravity_tick;
               state_d = CHECK;
            end else if (bus.drop_req) begin
               cand_d  = shift_down(cur_q, PLAY_WIDTH);
               op_d    = DOWN;
               state_d = CHECK;
            end else if (bus.left_req) begin
               cand_d  = shift_left(cur_q);
               op_d    = LEFT;
               state_d = CHECK;
            end else if (bus.right_req) begin
               cand_d  = shift_right(cur_q);
               op_d    = RIGHT;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (!bus.not_valid) begin
               cur_d   = cand_q;
               done_d  = 1'b1;
               ok_d    = 1'b1;
               state_d = RESOLVE;
               if (op_q == SPAWN) begin
                  active_d = 1'b1;
               end
            end else if (op_q == SPAWN) begin
               over_d  = 1'b1;
               state_d = OVER;
            end else begin
               done_d  = 1'b1;
               state_d = RESOLVE;
            end
         end
         RESOLVE: begin
            if (!ok_q && op_q == DOWN) begin
               lock_d  = 1'b1;
               state_d = LOCK;
            end else begin
               state_d = IDLE;
            end
         end
         LOCK: begin
            cur_d    = '0;
            active_d = 1'b0;
            state_d  = EMPTY;
         end
         OVER: begin
            state_d = OVER;
         end
         default: begin
            state_d = EMPTY;
         end
      endcase

      ready_d = (state_d == IDLE);
   end

   assign bus.req_ready     = ready_q;
   assign bus.cand_location = cand_q;
   assign bus.cur_location  = cur_q;
   assign bus.piece_active  = active_q;
   assign bus.move_done     = done_q;
   assign bus.move_ok       = ok_q;
   assign bus.piece_lock    = lock_q;
   assign bus.game_over     = over_q;

endmodule
